// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Fetch-unit bus bundle: pipeline control, imem port, delivery.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        fetch_err;

    // Driver side: pipeline control and the memory model.
    modport master (
        output freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
        input  imem_req, imem_addr, inst_valid, instruction, pc_out, fetch_err
    );

    // The fetch controller itself.
    modport slave (
        input  freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
        output imem_req, imem_addr, inst_valid, instruction, pc_out, fetch_err
    );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Single-outstanding instruction fetch FSM with redirect and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  wire          clk,
    input  wire          rst,
    fetch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DELIVER = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        redir_q, redir_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic        err_q, err_d;

    logic [31:0] w_pc_plus4;
    logic [7:0]  w_wait_inc;

    assign w_pc_plus4 = pc_q + 32'd4;
    assign w_wait_inc = wait_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            redir_q <= 1'b0;
            wait_q  <= 8'h0;
            instr_q <= 32'h0;
            pcout_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            redir_q <= redir_d;
            wait_q  <= wait_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        redir_d = redir_q;
        wait_d  = wait_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                wait_d  = 8'h0;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (bus.imem_ready) begin
                    wait_d = 8'h0;
                    if (bus.branch_taken) begin
                        pc_d    = bus.branch_addr;
                        redir_d = 1'b0;
                    end else if (redir_q) begin
                        pc_d    = tgt_q;
                        redir_d = 1'b0;
                    end else begin
                        instr_d = bus.imem_rdata;
                        pcout_d = w_pc_plus4;
                        state_d = S_DELIVER;
                    end
                end else begin
                    if (bus.branch_taken) begin
                        redir_d = 1'b1;
                        tgt_d   = bus.branch_addr;
                    end
                    wait_d = w_wait_inc;
                    if (w_wait_inc == C_MAX_WAIT) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end

            S_DELIVER: begin
                // A redirect outranks a downstream stall.
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_addr;
                    wait_d  = 8'h0;
                    state_d = S_FETCH;
                end else if (!bus.freeze) begin
                    pc_d    = w_pc_plus4;
                    wait_d  = 8'h0;
                    state_d = S_FETCH;
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.inst_valid  = (state_q == S_DELIVER);
    assign bus.instruction = instr_q;
    assign bus.pc_out      = pcout_q;
    assign bus.fetch_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Answer the outstanding request at address a after lat empty FETCH cycles.
    task automatic serve(input logic [31:0] a, input int lat);
        chk("serve_req", 32'(bus.imem_req), 32'd1);
        chk("serve_addr", bus.imem_addr, a);
        for (int i = 0; i < lat; i++) begin
            bus.imem_ready = 1'b0;
            tick();
            chk("hold_addr", bus.imem_addr, a);
            chk("hold_valid", 32'(bus.inst_valid), 32'd0);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1111_0000 + a;
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
    endtask

    task automatic chk_deliver(input string tag, input logic [31:0] instr, input logic [31:0] pco);
        chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, "_instr"}, bus.instruction, instr);
        chk({tag, "_pcout"}, bus.pc_out, pco);
    endtask

    initial begin
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = 32'h0;
        bus.imem_ready   = 1'b0;
        bus.imem_rdata   = 32'h0;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_instr", bus.instruction, 32'h0);
        chk("rst_pcout", bus.pc_out, 32'h0);
        chk("rst_err", 32'(bus.fetch_err), 32'd0);
        rst = 1'b0;
        tick();

        // Sequential fetches 0, 4, 8
        serve(32'h0, 1);
        chk_deliver("d0", 32'h1111_0000, 32'h4);
        tick();
        serve(32'h4, 1);
        chk_deliver("d4", 32'h1111_0004, 32'h8);
        tick();
        serve(32'h8, 1);
        chk_deliver("d8", 32'h1111_0008, 32'hC);

        // Freeze in DELIVER, with a stray ready that must be ignored
        bus.freeze     = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_deliver("frz", 32'h1111_0008, 32'hC);
        end
        bus.freeze     = 1'b0;
        bus.imem_ready = 1'b0;
        tick();
        chk("after_frz_req", 32'(bus.imem_req), 32'd1);
        chk("after_frz_addr", bus.imem_addr, 32'hC);

        // Branch while waiting; later branch_addr wins
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h20;
        tick();
        bus.branch_addr  = 32'h40;
        tick();
        bus.branch_taken = 1'b0;
        bus.branch_addr  = 32'h0;
        chk("redir_addr_hold", bus.imem_addr, 32'hC);
        chk("redir_valid", 32'(bus.inst_valid), 32'd0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h5555_5555;
        tick();
        bus.imem_ready = 1'b0;
        chk("redir_discard_valid", 32'(bus.inst_valid), 32'd0);
        serve(32'h40, 1);
        chk_deliver("d40", 32'h1111_0040, 32'h44);
        tick();

        // Branch coinciding with ready
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h80;
        bus.imem_ready   = 1'b1;
        bus.imem_rdata   = 32'h6666_6666;
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_ready   = 1'b0;
        chk("brrdy_valid", 32'(bus.inst_valid), 32'd0);
        serve(32'h80, 1);
        chk_deliver("d80", 32'h1111_0080, 32'h84);

        // Branch with freeze in DELIVER
        bus.branch_taken = 1'b1;
        bus.freeze       = 1'b1;
        bus.branch_addr  = 32'h80;
        tick();
        bus.branch_taken = 1'b0;
        bus.freeze       = 1'b0;
        chk("brfrz_valid", 32'(bus.inst_valid), 32'd0);

        // Wrap-around at the top of the address space
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'hFFFF_FFFC;
        bus.imem_ready   = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        bus.imem_ready   = 1'b0;
        serve(32'hFFFF_FFFC, 2);
        chk_deliver("dwrap", 32'h1110_FFFC, 32'h0);
        tick();
        chk("wrap_req", 32'(bus.imem_req), 32'd1);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Timeout: 15 FETCH cycles without ready
        for (int i = 0; i < 14; i++) tick();
        chk("to_pre_err", 32'(bus.fetch_err), 32'd0);
        chk("to_pre_req", 32'(bus.imem_req), 32'd1);
        tick();
        chk("to_err", 32'(bus.fetch_err), 32'd1);
        chk("to_req", 32'(bus.imem_req), 32'd0);
        chk("to_valid", 32'(bus.inst_valid), 32'd0);
        bus.imem_ready   = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h100;
        repeat (3) tick();
        chk("err_sticky", 32'(bus.fetch_err), 32'd1);
        chk("err_noreq", 32'(bus.imem_req), 32'd0);
        bus.imem_ready   = 1'b0;
        bus.branch_taken = 1'b0;

        // Reset clears the error and restarts at RESET_PC
        rst = 1'b1;
        tick();
        chk("rerst_err", 32'(bus.fetch_err), 32'd0);
        chk("rerst_addr", bus.imem_addr, 32'h0);
        rst = 1'b0;
        tick();
        chk("rerst_req", 32'(bus.imem_req), 32'd1);
        chk("rerst_addr2", bus.imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
